// File: rtl/gf8_horner_eval_if.sv
// Coefficient load, evaluation request and result handshake bundle for gf8_horner_eval.
interface gf8_horner_eval_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          clear;
  logic          coef_valid;
  logic [2:0]    coef_data;
  logic          coef_last;
  logic          coef_ready;
  logic          eval_start;
  logic [2:0]    x_pt;
  logic          busy;
  logic          res_valid;
  logic [2:0]    res_data;
  logic          res_ready;
  logic [CW-1:0] n_coef;

  modport master (
    output clear, coef_valid, coef_data, coef_last, eval_start, x_pt, res_ready,
    input  coef_ready, busy, res_valid, res_data, n_coef
  );

  modport slave (
    input  clear, coef_valid, coef_data, coef_last, eval_start, x_pt, res_ready,
    output coef_ready, busy, res_valid, res_data, n_coef
  );
endinterface

// File: rtl/gf8_horner_eval.sv
// Buffers up to DEPTH GF(2^3) coefficients and evaluates p(x) by Horner's rule.
// Define GF8_SERIAL_MUL_EN for a bit-serial multiplier (3 cycles per coefficient).
module gf8_horner_eval #(
  parameter int unsigned DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  gf8_horner_eval_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    buf_q [DEPTH];
  logic [2:0]    buf_d [DEPTH];
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [2:0]    acc_q, acc_d;
  logic [2:0]    x_q, x_d;
  logic [2:0]    cur_coef;
  logic [2:0]    step;
  logic          last_step;

`ifdef GF8_SERIAL_MUL_EN
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    prod_q, prod_d;
  logic [2:0]    pp;
`endif

  // Multiply by x, reduced by x^3+x+1.
  function automatic logic [2:0] xtime(input logic [2:0] a);
    return {a[1:0], 1'b0} ^ (a[2] ? 3'b011 : 3'b000);
  endfunction

`ifndef GF8_SERIAL_MUL_EN
  // Full product, MSB-first shift-and-add over the three bits of b.
  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    p = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      p = xtime(p) ^ (b[i] ? a : 3'b000);
    end
    return p;
  endfunction
`endif

  assign bus.coef_ready = (state_q == LOAD);
  assign bus.busy       = (state_q == EVAL) || (state_q == DONE);
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_data   = acc_q;
  assign bus.n_coef     = n_q;

  // Coefficient feeding the current Horner step.
  always_comb begin
    cur_coef = 3'b000;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) == idx_q) cur_coef = buf_q[i];
    end
  end

  assign last_step = (idx_q == n_q - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= 3'b000;
      x_q     <= 3'b000;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= 3'b000;
`ifdef GF8_SERIAL_MUL_EN
      ph_q    <= 2'd0;
      prod_q  <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
`ifdef GF8_SERIAL_MUL_EN
      ph_q    <= ph_d;
      prod_q  <= prod_d;
`endif
    end
  end

  // Next-state and datapath update; clear overrides everything.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    step    = 3'b000;
    for (int unsigned i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
`ifdef GF8_SERIAL_MUL_EN
    ph_d    = ph_q;
    prod_d  = prod_q;
    pp      = 3'b000;
`endif

    if (bus.clear) begin
      state_d = LOAD;
      n_d     = '0;
      idx_d   = '0;
      acc_d   = 3'b000;
`ifdef GF8_SERIAL_MUL_EN
      ph_d    = 2'd0;
      prod_d  = 3'b000;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.coef_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (CW'(i) == n_q) buf_d[i] = bus.coef_data;
            end
            n_d = n_q + CW'(1);
            // A full buffer acts as an implicit last.
            if (bus.coef_last || (n_q == CW'(DEPTH - 1))) state_d = READY;
          end
        end
        READY: begin
          if (bus.eval_start) begin
            state_d = EVAL;
            acc_d   = 3'b000;
            idx_d   = '0;
            x_d     = bus.x_pt;
`ifdef GF8_SERIAL_MUL_EN
            ph_d    = 2'd0;
            prod_d  = 3'b000;
`endif
          end
        end
        EVAL: begin
`ifdef GF8_SERIAL_MUL_EN
          // One multiplier bit per cycle, MSB first; fold in the coefficient on the third.
          pp = xtime(prod_q) ^ (x_q[2'd2 - ph_q] ? acc_q : 3'b000);
          if (ph_q == 2'd2) begin
            step   = pp ^ cur_coef;
            acc_d  = step;
            prod_d = 3'b000;
            ph_d   = 2'd0;
            idx_d  = idx_q + CW'(1);
            if (last_step) state_d = DONE;
          end else begin
            prod_d = pp;
            ph_d   = ph_q + 2'd1;
          end
`else
          step  = gf_mul(acc_q, x_q) ^ cur_coef;
          acc_d = step;
          idx_d = idx_q + CW'(1);
          if (last_step) state_d = DONE;
`endif
        end
        DONE: begin
          if (bus.res_ready) state_d = READY;
        end
        default: state_d = LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_gf8_horner_eval.sv
// Directed and randomized checks of gf8_horner_eval against a power-sum polynomial model.
module tb_gf8_horner_eval;
`ifdef GF8_SERIAL_MUL_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf8_horner_eval_if #(.DEPTH(DEPTH)) bus ();
  gf8_horner_eval #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int m_c [16];
  int m_n = 0;
  logic [2:0] exp_q [$];

  function automatic void chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Carry-less product followed by polynomial remainder mod 0b1011.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 3; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int k = 4; k >= 3; k--) if (((p >> k) & 1) == 1) p = p ^ (11 << (k - 3));
    return p & 7;
  endfunction

  function automatic int gpow(input int x, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = gmul(r, x);
    return r;
  endfunction

  // p(x) = sum over k of c[k] * x^(n-1-k), first-loaded coefficient has highest degree.
  function automatic int model_eval(input int x);
    int s;
    s = 0;
    for (int k = 0; k < m_n; k++) s = s ^ gmul(m_c[k], gpow(x, m_n - 1 - k));
    return s;
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_result: got res_data=%0d, expected no result", bus.res_data);
      end else begin
        chk("res_data", int'(bus.res_data), int'(exp_q[0]));
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input int n, input bit use_last);
    for (int k = 0; k < n; k++) begin
      bus.coef_valid = 1'b1;
      bus.coef_data  = 3'(m_c[k]);
      bus.coef_last  = use_last && (k == n - 1);
      tick();
    end
    bus.coef_valid = 1'b0;
    bus.coef_last  = 1'b0;
    m_n = (n > DEPTH) ? DEPTH : n;
  endtask

  // lit < 0 means no hand-computed value; hold > 0 keeps res_ready low that many cycles.
  task automatic eval(input int x, input int lit, input int hold);
    int cyc;
    exp_q.push_back(3'(model_eval(x)));
    bus.res_ready  = (hold == 0);
    bus.x_pt       = 3'(x);
    bus.eval_start = 1'b1;
    tick();
    bus.eval_start = 1'b0;
    cyc = 1;
    while (!bus.res_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!bus.res_valid) begin
      n_chk++;
      n_err++;
      $display("FAIL eval_timeout: got no res_valid after %0d cycles, expected at %0d", cyc, S * m_n + 1);
      exp_q.delete();
      bus.res_ready = 1'b1;
    end else begin
      chk("latency", cyc, S * m_n + 1);
      if (lit >= 0) chk("literal_result", int'(bus.res_data), lit);
      for (int h = 0; h < hold; h++) begin
        bus.eval_start = h[0];
        bus.x_pt       = 3'(h);
        tick();
        chk("hold_valid", int'(bus.res_valid), 1);
      end
      bus.eval_start = 1'b0;
      bus.res_ready  = 1'b1;
      tick();
      chk("done_exit_valid", int'(bus.res_valid), 0);
      chk("done_exit_busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.clear      = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = 3'd0;
    bus.coef_last  = 1'b0;
    bus.eval_start = 1'b0;
    bus.x_pt       = 3'd0;
    bus.res_ready  = 1'b1;

    #12;
    chk("rst_coef_ready", int'(bus.coef_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_n_coef", int'(bus.n_coef), 0);
    rst = 1'b0;
    tick();

    // eval_start in LOAD is ignored.
    bus.eval_start = 1'b1;
    tick();
    bus.eval_start = 1'b0;
    chk("load_eval_ignored", int'(bus.busy), 0);

    // [1,0,1] at x=2 -> 5
    m_c[0] = 1; m_c[1] = 0; m_c[2] = 1;
    load(3, 1'b1);
    chk("n_coef_3", int'(bus.n_coef), 3);
    chk("ready_coef_ready", int'(bus.coef_ready), 0);
    eval(2, 5, 0);

    // [1,1,1,1] at 3, 0, 1 without reloading
    do_clear();
    m_c[0] = 1; m_c[1] = 1; m_c[2] = 1; m_c[3] = 1;
    load(4, 1'b1);
    eval(3, 3, 0);
    eval(0, 1, 0);
    eval(1, 0, 0);

    // Eight ones, coef_last never asserted: buffer full acts as last.
    do_clear();
    for (int k = 0; k < 8; k++) m_c[k] = 1;
    load(8, 1'b0);
    chk("auto_last_n_coef", int'(bus.n_coef), 8);
    chk("auto_last_coef_ready", int'(bus.coef_ready), 0);
    chk("auto_last_busy", int'(bus.busy), 0);
    bus.coef_valid = 1'b1;
    bus.coef_data  = 3'd5;
    tick();
    bus.coef_valid = 1'b0;
    chk("extra_coef_ignored", int'(bus.n_coef), 8);
    eval(1, 0, 0);

    // Back-pressure in DONE with eval_start pulses; exactly one result.
    do_clear();
    m_c[0] = 6; m_c[1] = 3; m_c[2] = 7;
    load(3, 1'b1);
    eval(4, -1, 5);
    repeat (S * m_n + 3) tick();
    chk("no_second_result", int'(bus.res_valid), 0);
    chk("no_second_busy", int'(bus.busy), 0);

    // clear during EVAL step 2
    do_clear();
    m_c[0] = 3; m_c[1] = 5; m_c[2] = 7; m_c[3] = 2;
    load(4, 1'b1);
    bus.x_pt       = 3'd5;
    bus.eval_start = 1'b1;
    tick();
    bus.eval_start = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_n_coef", int'(bus.n_coef), 0);
    chk("clear_coef_ready", int'(bus.coef_ready), 1);
    chk("clear_busy", int'(bus.busy), 0);
    chk("clear_res_valid", int'(bus.res_valid), 0);
    repeat (20) tick();
    chk("clear_no_result", int'(bus.res_valid), 0);

    // Asynchronous reset mid-LOAD
    bus.coef_valid = 1'b1;
    bus.coef_data  = 3'd6;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_n_coef", int'(bus.n_coef), 0);
    chk("arst_coef_ready", int'(bus.coef_ready), 1);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_res_valid", int'(bus.res_valid), 0);
    chk("arst_res_data", int'(bus.res_data), 0);
    bus.coef_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    m_c[0] = 1; m_c[1] = 0; m_c[2] = 1;
    load(3, 1'b1);
    eval(2, 5, 0);

    // Randomized loads at every point
    for (int it = 0; it < 24; it++) begin
      int n;
      bit ul;
      do_clear();
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) m_c[k] = int'($urandom_range(0, 7));
      ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      load(n, ul);
      chk("rand_n_coef", int'(bus.n_coef), n);
      for (int x = 0; x < 8; x++) eval(x, -1, 0);
    end

    chk("pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
